audio_peak_meter: RTL and testbench
===================================

# audio_peak_meter

Stereo peak-level meter that consumes the 24-bit signed output of the moving-average filter stage on the same codec sample strobe. Per channel it tracks sample magnitude with peak-hold and exponential decay, and drives a 5-segment logarithmic LED bar per channel on the board's 10 red LEDs. An optional sticky clip detector flags full-scale samples.

## Interface
- `HOLD_SAMPLES`, default 4800: sample strobes a new peak is held before decay starts (100 ms at 48 kHz); must be ≥1.
- `DECAY_PERIOD`, default 480: sample strobes between decay steps; must be ≥1.
- `DECAY_SHIFT`, default 3: decay step is `peak >> DECAY_SHIFT`; range 1–22.

Ports:
- `CLOCK_50`, in, 1: single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `read_ready`, in, 1: codec read handshake.
- `write_ready`, in, 1: codec write handshake.
- `din_left`, in, 24: signed filtered left sample.
- `din_right`, in, 24: signed filtered right sample.
- `clip_clr`, in, 1: single-cycle clear of the clip flags.
- `peak_left`, out, 23: unsigned left peak magnitude.
- `peak_right`, out, 23: unsigned right peak magnitude.
- `ledr`, out, 10: `[9:5]` is the left bar (segment i on `ledr[5+i]`); `[4:0]` is the right bar (segment i on `ledr[i]`).
- `clip`, out, 2: `[1]` is the left sticky clip flag, `[0]` is the right.

## Operation
- Sample strobe `go = read_ready & write_ready`. Nothing updates on cycles without `go`.
- Magnitude: `mag = din < 0 ? -din : din`, 23 bits unsigned. −8388608 saturates to 8388607.
- Each channel has an independent FSM with states HOLD and DECAY, a hold counter, and a decay counter. On `go`:
  - `mag >= peak` (any state): `peak <= mag`, `hold_cnt <= HOLD_SAMPLES-1`, go to HOLD. Equality also restarts hold.
  - HOLD, `hold_cnt != 0`: decrement `hold_cnt`.
  - HOLD, `hold_cnt == 0`: go to DECAY, `dec_cnt <= DECAY_PERIOD-1`.
  - DECAY, `dec_cnt != 0`: decrement `dec_cnt`.
  - DECAY, `dec_cnt == 0`: `peak <= peak - max(peak >> DECAY_SHIFT, peak != 0)`, so the peak always reaches 0. Reload `dec_cnt <= DECAY_PERIOD-1`.
  - DECAY with `peak == 0` stays in DECAY with `peak` at 0.
- LED bar: segment i (0–4) is lit when `peak >= 2^(10+3i)`, i.e. thresholds 1024, 8192, 65536, 524288, 4194304. The bar is monotonic: a lit segment implies all lower segments are lit.
- Clip detection (macro-dependent, see Configuration): on `go`, `din == 24'h7FFFFF` or `din == 24'h800000` sets that channel's clip bit. `clip_clr` clears both bits. If set and clear occur in the same cycle, set wins.

## Timing
- Reset (`reset_n` low) takes effect immediately, without a clock edge:
  - `peak_*` = 0, `ledr` = 0, `clip` = 0.
  - FSMs go to DECAY with both counters at 0.
- Reset asserted mid-hold or mid-decay discards all state. The first `go` after release behaves as from power-up.
- `peak_*` update on the clock edge where `go` is high (1-cycle latency from the strobe).
- `ledr` is registered from `peak_*`: it updates one cycle after `peak_*`.
- `clip` is set on the edge where `go` is high. `clip_clr` acts on the edge where it is high.
- `go` held high for consecutive cycles counts as one strobe per cycle.
- `din_*` are sampled only on `go` edges and need not be stable otherwise.

## Configuration
- `AUDIO_PEAK_METER_CLIP_EN` defined: clip detector, `clip` register, and `clip_clr` logic are compiled in as described.
- Not defined: `clip` is tied to 2'b00 and `clip_clr` is ignored. Ports are unchanged and all other behaviour is identical.

## Test plan
Parameters for all scenarios: `HOLD_SAMPLES=4`, `DECAY_PERIOD=2`, `DECAY_SHIFT=1`. Clip tests use a build with `AUDIO_PEAK_METER_CLIP_EN` defined.
- **Async reset mid-operation:** peak 1000 held; assert `reset_n=0` between clock edges. Required: `peak_*`, `ledr`, and `clip` read 0 immediately. After release, one `go` with `din_left=5` gives `peak_left=5`.
- **Capture and LED bar:** `go` with `din_left=1048576`, `din_right=0`. Required: `peak_left=1048576` next cycle; one cycle later `ledr[9:5]=01111`, `ledr[4:0]=00000`.
- **Hold then decay:** `go` with `din_left=1000`, then `go` strobes with 0. Required: `peak_left` stays 1000 through 5 strobes, becomes 500 on the 6th, 250 on the 8th, and eventually steps 1→0 and stays 0.
- **Negative full scale:** `go` with `din_left=-8388608`. Required: `peak_left=8388607`, `ledr[9:5]=11111`, `clip=2'b10`. Pulse `clip_clr` → `clip=2'b00`. Simultaneous `go` with `din_right=8388607` and `clip_clr` → `clip=2'b01`.
- **Strobe gating:** `read_ready=1`, `write_ready=0`, `din_left=2000000` for 10 cycles. Required: `peak_left` and `ledr` unchanged.
- **Hold restart:** peak 1000 in DECAY at 500; `go` with 500. Required: `peak_left=500`, FSM back in HOLD, and no decay for the next 4 strobes.

Source files
------------

// File: rtl/audio_peak_meter.sv
// audio_peak_meter: stereo peak-level meter with peak-hold, exponential decay
// and a 5-segment logarithmic LED bar per channel.
// Optional feature macro: AUDIO_PEAK_METER_CLIP_EN compiles in the sticky
// per-channel clip detector; without it clip reads 2'b00 and clip_clr is ignored.

// One channel: magnitude, HOLD/DECAY peak tracker and registered LED bar.
module audio_peak_meter_ch #(
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned DECAY_PERIOD = 480,
  parameter int unsigned DECAY_SHIFT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go_i,
  input  logic [23:0] din_i,
  output logic [22:0] peak_o,
  output logic [4:0]  bar_o
);

  localparam int unsigned HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam int unsigned DEC_W  = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [DEC_W-1:0]  DEC_RELOAD  = DEC_W'(DECAY_PERIOD - 1);

  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_DECAY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [22:0]       peak_q, peak_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic [4:0]        bar_q, bar_d;

  logic [23:0] din_neg;
  logic [22:0] mag;
  logic [22:0] shifted;
  logic [22:0] dec_step;
  logic        new_peak;

  // Magnitude with the single unrepresentable value (-2^23) saturated.
  assign din_neg = ~din_i + 24'd1;
  assign mag     = !din_i[23]              ? din_i[22:0] :
                   (din_i == 24'h800000)   ? 23'h7FFFFF  : din_neg[22:0];

  // Decay step never rounds to zero while the peak is non-zero, so the
  // meter always returns to silence.
  assign shifted  = peak_q >> DECAY_SHIFT;
  assign dec_step = (shifted == 23'd0 && peak_q != 23'd0) ? 23'd1 : shifted;

  // A zero sample on an already-zero decayed peak is not a new peak; the
  // tracker simply rests in DECAY.
  assign new_peak = (mag >= peak_q) &&
                    !(state_q == ST_DECAY && peak_q == 23'd0 && mag == 23'd0);

  // Next-state logic for the peak tracker, evaluated only on sample strobes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    if (go_i) begin
      if (new_peak) begin
        peak_d     = mag;
        hold_cnt_d = HOLD_RELOAD;
        state_d    = ST_HOLD;
      end else begin
        unique case (state_q)
          ST_HOLD: begin
            if (hold_cnt_q != '0) begin
              hold_cnt_d = hold_cnt_q - 1'b1;
            end else begin
              state_d   = ST_DECAY;
              dec_cnt_d = DEC_RELOAD;
            end
          end
          ST_DECAY: begin
            if (dec_cnt_q != '0) begin
              dec_cnt_d = dec_cnt_q - 1'b1;
            end else begin
              peak_d    = peak_q - dec_step;
              dec_cnt_d = DEC_RELOAD;
            end
          end
          default: state_d = ST_DECAY;
        endcase
      end
    end
  end

  // Logarithmic bar thresholds 2^10, 2^13, 2^16, 2^19, 2^22 (monotonic by construction).
  always_comb begin
    bar_d = '0;
    for (int i = 0; i < 5; i++) begin
      bar_d[i] = (peak_q >= (23'd1 << (10 + 3 * i)));
    end
  end

  // State, peak and counter registers; reset parks the tracker in DECAY at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q    <= ST_DECAY;
      peak_q     <= '0;
      hold_cnt_q <= '0;
      dec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
    end
  end

  // LED bar register trails the peak register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q <= '0;
    end else begin
      bar_q <= bar_d;
    end
  end

  assign peak_o = peak_q;
  assign bar_o  = bar_q;

endmodule

// Top level: two channel trackers, LED mapping and optional clip flags.
module audio_peak_meter #(
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned DECAY_PERIOD = 480,
  parameter int unsigned DECAY_SHIFT  = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        read_ready,
  input  logic        write_ready,
  input  logic [23:0] din_left,
  input  logic [23:0] din_right,
  input  logic        clip_clr,
  output logic [22:0] peak_left,
  output logic [22:0] peak_right,
  output logic [9:0]  ledr,
  output logic [1:0]  clip
);

  logic       go;
  logic [4:0] bar_left, bar_right;

  assign go = read_ready & write_ready;

  audio_peak_meter_ch #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .DECAY_PERIOD (DECAY_PERIOD),
    .DECAY_SHIFT  (DECAY_SHIFT)
  ) u_left (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .go_i   (go),
    .din_i  (din_left),
    .peak_o (peak_left),
    .bar_o  (bar_left)
  );

  audio_peak_meter_ch #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .DECAY_PERIOD (DECAY_PERIOD),
    .DECAY_SHIFT  (DECAY_SHIFT)
  ) u_right (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .go_i   (go),
    .din_i  (din_right),
    .peak_o (peak_right),
    .bar_o  (bar_right)
  );

  assign ledr = {bar_left, bar_right};

`ifdef AUDIO_PEAK_METER_CLIP_EN
  logic [1:0] clip_q, clip_d;
  logic [1:0] clip_set;

  assign clip_set[1] = go & ((din_left  == 24'h7FFFFF) | (din_left  == 24'h800000));
  assign clip_set[0] = go & ((din_right == 24'h7FFFFF) | (din_right == 24'h800000));

  // Sticky clip flags: clear first, then a same-cycle set overrides it.
  always_comb begin
    clip_d = clip_clr ? 2'b00 : clip_q;
    clip_d = clip_d | clip_set;
  end

  // Clip flag register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clip_q <= 2'b00;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign clip = clip_q;
`else
  logic unused_clip_clr;
  assign unused_clip_clr = clip_clr;
  assign clip            = 2'b00;
`endif

endmodule

// File: tb/tb_audio_peak_meter.sv
// Scoreboard bench for audio_peak_meter (HOLD_SAMPLES=4, DECAY_PERIOD=2,
// DECAY_SHIFT=1). Stimulus pushes expected values tagged with the cycle they
// become visible; a negedge monitor pops and compares them.
module tb_audio_peak_meter;

  typedef enum {S_PEAK_L, S_PEAK_R, S_LEDR, S_CLIP} sig_e;
  typedef struct {
    sig_e        sig;
    int unsigned due;
    logic [22:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_ready = 1'b0;
  logic        write_ready = 1'b0;
  logic [23:0] din_left = '0;
  logic [23:0] din_right = '0;
  logic        clip_clr = 1'b0;
  logic [22:0] peak_left, peak_right;
  logic [9:0]  ledr;
  logic [1:0]  clip;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];

  audio_peak_meter #(
    .HOLD_SAMPLES (4),
    .DECAY_PERIOD (2),
    .DECAY_SHIFT  (1)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .read_ready  (read_ready),
    .write_ready (write_ready),
    .din_left    (din_left),
    .din_right   (din_right),
    .clip_clr    (clip_clr),
    .peak_left   (peak_left),
    .peak_right  (peak_right),
    .ledr        (ledr),
    .clip        (clip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  // Monitor: compare every expectation due at this cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [22:0] act;
    while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      case (e.sig)
        S_PEAK_L: act = peak_left;
        S_PEAK_R: act = peak_right;
        S_LEDR:   act = {13'd0, ledr};
        default:  act = {21'd0, clip};
      endcase
      check(e.sig.name(), act, e.val);
      if (e.due != cyc) begin
        n_fail++;
        $display("FAIL %s: due cycle %0d, checked cycle %0d", e.sig.name(), e.due, cyc);
      end
    end
  end

  task automatic push_exp(input sig_e s, input logic [22:0] v, input int unsigned dly);
    exp_t e;
    e.sig = s;
    e.due = cyc + dly;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sample strobe; back-to-back calls keep go high continuously.
  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    read_ready  = 1'b1;
    write_ready = 1'b1;
    din_left    = l;
    din_right   = r;
    @(posedge clk);
    #1;
    read_ready  = 1'b0;
    write_ready = 1'b0;
  endtask

  // Assert reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset peak_left",  peak_left,          23'd0);
    check("reset peak_right", peak_right,         23'd0);
    check("reset ledr",       {13'd0, ledr},      23'd0);
    check("reset clip",       {21'd0, clip},      23'd0);
    push_exp(S_PEAK_L, 23'd0, 0);
    push_exp(S_PEAK_R, 23'd0, 0);
    push_exp(S_LEDR,   23'd0, 0);
    push_exp(S_CLIP,   23'd0, 0);
    idle(1);
    reset_n = 1'b1;
  endtask

  int hold_tab[30] = '{1000, 1000, 1000, 1000, 1000, 500, 500, 250, 250, 125,
                       125, 63, 63, 32, 32, 16, 16, 8, 8, 4,
                       4, 2, 2, 1, 1, 0, 0, 0, 0, 0};
  logic [1:0] clip_l_exp, clip_clr_exp, clip_r_exp;

  initial begin
`ifdef AUDIO_PEAK_METER_CLIP_EN
    clip_l_exp   = 2'b10;
    clip_clr_exp = 2'b00;
    clip_r_exp   = 2'b01;
`else
    clip_l_exp   = 2'b00;
    clip_clr_exp = 2'b00;
    clip_r_exp   = 2'b00;
`endif

    // Power-up reset.
    idle(2);
    do_reset();

    // Capture and LED bar, left then a negative right sample.
    strobe(24'd1048576, 24'd0);
    check("capture peak_left", peak_left, 23'd1048576);
    push_exp(S_PEAK_L, 23'd1048576, 0);
    push_exp(S_PEAK_R, 23'd0, 0);
    push_exp(S_LEDR, 23'(10'b01111_00000), 1);
    idle(1);
    strobe(24'd0, 24'(-70000));
    push_exp(S_PEAK_R, 23'd70000, 0);
    push_exp(S_PEAK_L, 23'd1048576, 0);
    push_exp(S_LEDR, 23'(10'b01111_00111), 1);
    idle(2);

    // Async reset mid-hold, then first strobe behaves as from power-up.
    do_reset();
    strobe(24'd1000, 24'd0);
    push_exp(S_PEAK_L, 23'd1000, 0);
    idle(2);
    do_reset();
    strobe(24'd5, 24'd0);
    push_exp(S_PEAK_L, 23'd5, 0);
    idle(2);

    // Hold then decay down to zero and staying there.
    do_reset();
    strobe(24'd1000, 24'd0);
    push_exp(S_PEAK_L, 23'd1000, 0);
    for (int k = 0; k < 30; k++) begin
      strobe(24'd0, 24'd0);
      push_exp(S_PEAK_L, 23'(hold_tab[k]), 0);
    end
    idle(2);

    // Negative full scale: saturation, full bar, clip set/clear/set-wins.
    do_reset();
    strobe(24'h800000, 24'd0);
    push_exp(S_PEAK_L, 23'd8388607, 0);
    push_exp(S_CLIP, 23'(clip_l_exp), 0);
    push_exp(S_LEDR, 23'(10'b11111_00000), 1);
    idle(1);
    clip_clr = 1'b1;
    idle(1);
    clip_clr = 1'b0;
    push_exp(S_CLIP, 23'(clip_clr_exp), 0);
    idle(1);
    clip_clr = 1'b1;
    strobe(24'd0, 24'd8388607);
    clip_clr = 1'b0;
    push_exp(S_CLIP, 23'(clip_r_exp), 0);
    push_exp(S_PEAK_R, 23'd8388607, 0);
    idle(2);

    // Strobe gating: half handshakes must not update or count.
    do_reset();
    strobe(24'd1000, 24'd0);
    push_exp(S_PEAK_L, 23'd1000, 0);
    idle(1);
    read_ready  = 1'b1;
    write_ready = 1'b0;
    din_left    = 24'd2000000;
    idle(10);
    read_ready  = 1'b0;
    write_ready = 1'b1;
    idle(2);
    write_ready = 1'b0;
    push_exp(S_PEAK_L, 23'd1000, 0);
    push_exp(S_LEDR, 23'd0, 0);
    for (int k = 0; k < 6; k++) begin
      strobe(24'd0, 24'd0);
      push_exp(S_PEAK_L, (k < 5) ? 23'd1000 : 23'd500, 0);
    end
    idle(2);

    // Hold restart on equality while decaying.
    do_reset();
    strobe(24'd1000, 24'd0);
    for (int k = 0; k < 6; k++) begin
      strobe(24'd0, 24'd0);
    end
    push_exp(S_PEAK_L, 23'd500, 0);
    strobe(24'd500, 24'd0);
    push_exp(S_PEAK_L, 23'd500, 0);
    for (int k = 0; k < 6; k++) begin
      strobe(24'd0, 24'd0);
      push_exp(S_PEAK_L, (k < 5) ? 23'd500 : 23'd250, 0);
    end
    idle(3);

    // Anything still queued was never compared.
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked, expected %0d at cycle %0d", e.sig.name(), e.val, e.due);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
